// File: rtl/logic_unit_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter_if
// Description : Request/response bundle between N_REQ requesters and the
//               shared logic-unit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_unit_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [2*N_REQ-1:0]     req_op;
    logic [WIDTH*N_REQ-1:0] req_a;
    logic [WIDTH*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_data;
    logic                   rsp_ready;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter
// Description : Round-robin arbiter sharing one AND/OR/XOR/NOR unit between
//               N_REQ requesters, with a single id-tagged response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
    parameter int WIDTH = 4,
    parameter int N_REQ = 4
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    logic_unit_arbiter_if.slave   bus
);
    localparam int ID_W = $clog2(N_REQ);

    localparam logic [1:0] c_OP_AND = 2'b00;
    localparam logic [1:0] c_OP_OR  = 2'b01;
    localparam logic [1:0] c_OP_XOR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [ID_W-1:0]   id_q,       id_d;
    logic [1:0]        op_q,       op_d;
    logic [WIDTH-1:0]  a_q,        a_d;
    logic [WIDTH-1:0]  b_q,        b_d;
    logic [ID_W-1:0]   rsp_id_q,   rsp_id_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;

    logic              w_grant_found;
    logic [ID_W-1:0]   w_grant_id;
    logic [N_REQ-1:0]  w_grant_onehot;
    logic [N_REQ-1:0]  w_req_ready;
    logic [WIDTH-1:0]  w_lu_result;

    // Search upward from rr_ptr, wrapping at N_REQ (not 2**ID_W).
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_grant_found && bus.req_valid[idx]) begin
                w_grant_found = 1'b1;
                w_grant_id    = ID_W'(idx);
            end
        end
        w_grant_onehot = w_grant_found ? (N_REQ'(1) << w_grant_id) : '0;
    end

    always_comb begin
        case (op_q)
            c_OP_AND: w_lu_result = a_q & b_q;
            c_OP_OR:  w_lu_result = a_q | b_q;
            c_OP_XOR: w_lu_result = a_q ^ b_q;
            default:  w_lu_result = ~(a_q | b_q);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        w_req_ready = '0;

        case (state_q)
            S_IDLE: begin
                // Reset forces ready low in the same cycle so nothing is taken.
                if (w_grant_found && !rst_i) begin
                    w_req_ready = w_grant_onehot;
                    id_d        = w_grant_id;
                    op_d        = bus.req_op[2*w_grant_id +: 2];
                    a_d         = bus.req_a[WIDTH*w_grant_id +: WIDTH];
                    b_d         = bus.req_b[WIDTH*w_grant_id +: WIDTH];
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d = w_lu_result;
                rsp_id_d   = id_q;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rr_ptr_d = (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + ID_W'(1);
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_arbiter
// Description : Scoreboard bench for logic_unit_arbiter (round-robin grants,
//               opcode results, backpressure, mid-operation reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;
    localparam int WIDTH  = 4;
    localparam int N_REQ  = 4;
    localparam int M_IDLE = 0;
    localparam int M_EXEC = 1;
    localparam int M_RESP = 2;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic_unit_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

    logic_unit_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   hs_cyc[$];
    int   m_state = M_IDLE;
    int   m_ptr   = 0;
    int   cyc     = 0;
    int   last_rsp_id   = -1;
    int   last_rsp_data = -1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] lu_model(input logic [1:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Reference model sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        int               g;
        logic [N_REQ-1:0] exp_rdy;
        exp_t             e;
        cyc++;
        g       = -1;
        exp_rdy = '0;
        if (!rst && m_state == M_IDLE) begin
            for (int i = 0; i < N_REQ; i++) begin
                int k;
                k = (m_ptr + i) % N_REQ;
                if (g < 0 && bus.req_valid[k]) g = k;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_value("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check_value("rsp_valid", 32'(bus.rsp_valid), 32'(m_state == M_RESP));

        if (rst) begin
            m_state = M_IDLE;
            m_ptr   = 0;
            sb.delete();
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (g >= 0) begin
                        e.id   = g;
                        e.data = lu_model(bus.req_op[2*g +: 2], bus.req_a[WIDTH*g +: WIDTH],
                                          bus.req_b[WIDTH*g +: WIDTH]);
                        sb.push_back(e);
                        grant_log.push_back(g);
                        grant_cyc.push_back(cyc);
                        m_state = M_EXEC;
                    end
                end
                M_EXEC: m_state = M_RESP;
                default: begin
                    if (sb.size() == 0) begin
                        check_value("rsp_unexpected", 32'd1, 32'd0);
                        if (bus.rsp_ready) m_state = M_IDLE;
                    end else begin
                        check_value("rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
                        check_value("rsp_data", 32'(bus.rsp_data), 32'(sb[0].data));
                        if (bus.rsp_ready) begin
                            e             = sb.pop_front();
                            last_rsp_id   = int'(bus.rsp_id);
                            last_rsp_data = int'(bus.rsp_data);
                            hs_cyc.push_back(cyc);
                            m_ptr   = (e.id + 1) % N_REQ;
                            m_state = M_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [1:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic v);
        bus.req_op[2*k +: 2]        = op;
        bus.req_a[WIDTH*k +: WIDTH] = a;
        bus.req_b[WIDTH*k +: WIDTH] = b;
        bus.req_valid[k]            = v;
    endtask

    task automatic wait_grant_count(input int target);
        int t = 0;
        while (grant_log.size() < target && t < 50) begin
            tick();
            t++;
        end
        check_value("grant_timeout", 32'(grant_log.size() >= target), 32'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(m_state == M_IDLE && sb.size() == 0) && t < 50) begin
            tick();
            t++;
        end
        check_value("idle_timeout", 32'(m_state == M_IDLE && sb.size() == 0), 32'd1);
    endtask

    task automatic do_req(input int k, input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        int n = grant_log.size();
        set_req(k, op, a, b, 1'b1);
        wait_grant_count(n + 1);
        bus.req_valid[k] = 1'b0;
        if (grant_log.size() > n) check_value("grant_id", 32'(grant_log[n]), 32'(k));
        wait_idle();
    endtask

    initial begin
        int n;
        int h;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [WIDTH-1:0] exp_sweep[3] = '{4'hE, 4'h6, 4'h1};

        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) tick();

        // Reset state; ready must stay low even with every request valid.
        bus.req_valid = '1;
        #1;
        check_value("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_value("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_value("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        check_value("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        bus.req_valid = '0;
        tick();
        rst = 1'b0;
        tick();

        // Basic AND on requester 0 and its latency.
        do_req(0, 2'b00, 4'hC, 4'hA);
        check_value("t1_data", 32'(last_rsp_data), 32'h8);
        check_value("t1_id",   32'(last_rsp_id),   32'd0);
        if (hs_cyc.size() > 0 && grant_cyc.size() > 0)
            check_value("t1_latency", 32'(hs_cyc[0] - grant_cyc[0]), 32'd2);

        // Opcode sweep on requester 2.
        for (int op = 1; op < 4; op++) begin
            do_req(2, 2'(op), 4'hC, 4'hA);
            check_value("t2_data", 32'(last_rsp_data), 32'(exp_sweep[op-1]));
            check_value("t2_id",   32'(last_rsp_id),   32'd2);
        end

        // All requesters continuously valid from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = grant_log.size();
        for (int k = 0; k < N_REQ; k++) set_req(k, 2'(k), 4'(k + 3), 4'(9 - k), 1'b1);
        wait_grant_count(n + 5);
        bus.req_valid = '0;
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            if (grant_log.size() > n + i) begin
                check_value("t3_order", 32'(grant_log[n+i]), 32'(exp_order[i]));
                if (i > 0) check_value("t3_no_repeat", 32'(grant_log[n+i] == grant_log[n+i-1]), 32'd0);
            end
        end

        // Backpressure in RESP with requester 1 pending.
        bus.rsp_ready = 1'b0;
        n = grant_log.size();
        set_req(0, 2'b01, 4'h5, 4'hA, 1'b1);
        wait_grant_count(n + 1);
        bus.req_valid[0] = 1'b0;
        set_req(1, 2'b10, 4'h9, 4'h3, 1'b1);
        repeat (7) tick();
        check_value("t4_held_valid", 32'(bus.rsp_valid), 32'd1);
        h = hs_cyc.size();
        bus.rsp_ready = 1'b1;
        wait_grant_count(n + 2);
        bus.req_valid[1] = 1'b0;
        if (grant_log.size() > n + 1 && hs_cyc.size() > h) begin
            check_value("t4_grant_id",  32'(grant_log[n+1]), 32'd1);
            check_value("t4_grant_gap", 32'(grant_cyc[n+1] - hs_cyc[h]), 32'd1);
        end
        wait_idle();

        // Reset while EXEC: request discarded, pointer back to 0.
        n = grant_log.size();
        set_req(2, 2'b11, 4'h6, 4'h1, 1'b1);
        wait_grant_count(n + 1);
        bus.req_valid[2] = 1'b0;
        set_req(0, 2'b00, 4'hF, 4'h3, 1'b1);
        set_req(3, 2'b01, 4'h3, 4'h0, 1'b1);
        rst = 1'b1;
        tick();
        check_value("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_value("t5_rsp_id",    32'(bus.rsp_id),    32'd0);
        check_value("t5_rsp_data",  32'(bus.rsp_data),  32'd0);
        check_value("t5_req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        wait_grant_count(n + 2);
        bus.req_valid = '0;
        if (grant_log.size() > n + 1) check_value("t5_ptr_reset", 32'(grant_log[n+1]), 32'd0);
        wait_idle();

        // Operands changed right after the accept edge.
        n = grant_log.size();
        set_req(3, 2'b10, 4'h5, 4'h3, 1'b1);
        wait_grant_count(n + 1);
        set_req(3, 2'b00, 4'hF, 4'hF, 1'b0);
        wait_idle();
        check_value("t6_data", 32'(last_rsp_data), 32'h6);
        check_value("t6_id",   32'(last_rsp_id),   32'd3);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
